// File: rtl/lv2_pkg.sv
// Shared constants, types and helpers for the LV2 buffer-full / L1A-request producer.
package lv2_pkg;

    localparam int LV2_DEPTH    = 16;
    localparam int LV2_AW       = 4;
    localparam int LV2_TAG_W    = 32;
    localparam int LV2_FULL_THR = 16;
    localparam int LV2_CNT_W    = 32;

    typedef logic [LV2_TAG_W-1:0] lv2_tag_t;
    typedef logic [LV2_CNT_W-1:0] lv2_cnt_t;

    // Accepted-request counter sticks at all-ones rather than wrapping.
    function automatic lv2_cnt_t lv2_sat_inc(input lv2_cnt_t v);
        return (v == '1) ? v : v + LV2_CNT_W'(1);
    endfunction

endpackage : lv2_pkg

// File: rtl/lv2_tag_fifo.sv
// First-word-fall-through tag FIFO with synchronous flush; flush wins over push and pop.
module lv2_tag_fifo
    import lv2_pkg::*;
#(
    parameter int DEPTH = LV2_DEPTH,
    parameter int AW    = LV2_AW,
    parameter int TAG_W = LV2_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_din,
    input  logic             i_pop,
    output logic [TAG_W-1:0] o_dout,
    output logic             o_valid,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !i_flush && (r_count != LP_FULL);
    assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; o_count/o_valid alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Head is forced to zero while empty so stale storage never leaks onto the tag bus.
    assign o_valid = (r_count != '0);
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule : lv2_tag_fifo

// File: rtl/lv2_buf_ctrl.sv
// LV2 buffer producer: live-edge flush, L1A accept gating, event tagging and registered buffer-full.
module lv2_buf_ctrl
    import lv2_pkg::*;
#(
    parameter int DEPTH    = LV2_DEPTH,
    parameter int AW       = LV2_AW,
    parameter int TAG_W    = LV2_TAG_W,
    parameter int FULL_THR = LV2_FULL_THR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_live,
    input  logic             lv1a_req,
    output logic             lv2_buffer_full,
    output logic             lv1a_acc,
    output logic             ev_valid,
    output logic [TAG_W-1:0] ev_tag,
    input  logic             ev_ready,
    output logic [AW:0]      occupancy,
    output logic [31:0]      l1a_acc_cnt
);

    localparam logic [AW:0] LP_THR = (AW+1)'(FULL_THR);

    logic             r_pre_live;
    logic             r_full;
    logic             r_acc;
    logic [TAG_W-1:0] r_tag;
    lv2_cnt_t         r_acc_cnt;

    logic             w_live_start;
    logic             w_accept;
    logic             w_pop;
    logic [AW:0]      w_count;
    logic [AW:0]      w_occ_next;
    logic [TAG_W-1:0] w_head;
    logic             w_valid;

    assign w_live_start = in_live && !r_pre_live;
    assign w_accept     = lv1a_req && in_live && !r_full && !w_live_start;
    assign w_pop        = w_valid && ev_ready;

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        w_occ_next = w_count;
        if (w_live_start) begin
            w_occ_next = '0;
        end else begin
            w_occ_next = w_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_live <= 1'b0;
            r_full     <= 1'b0;
            r_acc      <= 1'b0;
            r_tag      <= '0;
            r_acc_cnt  <= '0;
        end else begin
            r_pre_live <= in_live;
            r_acc      <= w_accept;
            // Full is built from the next-state count so accept gating sees it one cycle after the edge.
            r_full     <= (w_occ_next >= LP_THR);
            if (w_live_start) begin
                r_tag     <= '0;
                r_acc_cnt <= '0;
            end else if (w_accept) begin
                r_tag     <= r_tag + TAG_W'(1);
                r_acc_cnt <= lv2_sat_inc(r_acc_cnt);
            end
        end
    end

    lv2_tag_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_live_start),
        .i_push  (w_accept),
        .i_din   (r_tag),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign lv2_buffer_full = r_full;
    assign lv1a_acc        = r_acc;
    assign ev_valid        = w_valid;
    assign ev_tag          = w_head;
    assign occupancy       = w_count;
    assign l1a_acc_cnt     = r_acc_cnt;

endmodule : lv2_buf_ctrl

// File: tb/tb_lv2_buf_ctrl.sv
// Self-checking bench for lv2_buf_ctrl: directed table, corner sequences and a queue-based random model.
module tb_lv2_buf_ctrl;
    import lv2_pkg::*;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int TAG_W    = 32;
    localparam int FULL_THR = 16;

    logic             clk;
    logic             rst_n;
    logic             in_live;
    logic             lv1a_req;
    logic             lv2_buffer_full;
    logic             lv1a_acc;
    logic             ev_valid;
    logic [TAG_W-1:0] ev_tag;
    logic             ev_ready;
    logic [AW:0]      occupancy;
    logic [31:0]      l1a_acc_cnt;

    lv2_buf_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .TAG_W    (TAG_W),
        .FULL_THR (FULL_THR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_live         (in_live),
        .lv1a_req        (lv1a_req),
        .lv2_buffer_full (lv2_buffer_full),
        .lv1a_acc        (lv1a_acc),
        .ev_valid        (ev_valid),
        .ev_tag          (ev_tag),
        .ev_ready        (ev_ready),
        .occupancy       (occupancy),
        .l1a_acc_cnt     (l1a_acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: event queue plus counters, advanced once per clock edge.
    lv2_tag_t    m_q[$];
    lv2_tag_t    m_tag;
    logic [31:0] m_cnt;
    logic        m_full;
    logic        m_acc;
    logic        m_pre;

    typedef struct {
        logic        live;
        logic        req;
        logic        ready;
        logic        exp_acc;
        logic        exp_valid;
        logic [31:0] exp_tag;
        logic [4:0]  exp_occ;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tag  = '0;
        m_cnt  = '0;
        m_full = 1'b0;
        m_acc  = 1'b0;
        m_pre  = 1'b0;
    endtask

    task automatic compare_model();
        check("acc", lv1a_acc, m_acc);
        check("full", lv2_buffer_full, m_full);
        check("valid", ev_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("tag", ev_tag, m_q[0]);
        check("occ", occupancy, m_q.size());
        check("cnt", l1a_acc_cnt, m_cnt);
        check("occ_le_depth", occupancy <= DEPTH, 1);
    endtask

    // Called at a falling edge: drive inputs, advance the model across the rising edge, compare.
    task automatic step(input logic live, input logic req, input logic ready);
        bit ls, pop, acc;
        in_live  = live;
        lv1a_req = req;
        ev_ready = ready;
        @(posedge clk);
        ls  = live && !m_pre;
        pop = (m_q.size() != 0) && ready;
        acc = req && live && !m_full && !ls;
        if (ls) begin
            m_q.delete();
            m_tag = '0;
            m_cnt = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(m_tag);
                m_tag++;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
        end
        m_full = (m_q.size() >= FULL_THR);
        m_acc  = acc;
        m_pre  = live;
        @(negedge clk);
        compare_model();
    endtask

    // Called at a falling edge: pulse reset between edges and check outputs clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_acc", lv1a_acc, 0);
        check("rst_full", lv2_buffer_full, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_tag", ev_tag, 0);
        check("rst_occ", occupancy, 0);
        check("rst_cnt", l1a_acc_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int       n_acc;
        lv2_tag_t last_tag;
        int       rdy_pct;

        rst_n    = 1'b0;
        in_live  = 1'b0;
        lv1a_req = 1'b0;
        ev_ready = 1'b0;
        model_reset();
        #1;
        check("init_acc", lv1a_acc, 0);
        check("init_valid", ev_valid, 0);
        check("init_occ", occupancy, 0);
        check("init_full", lv2_buffer_full, 0);
        check("init_cnt", l1a_acc_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Live rise with a request ignored, then three accepts drained straight away.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 5'd1, 32'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 5'd1, 32'd2};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 5'd1, 32'd3};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 32'd3};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 32'd3};
        foreach (vecs[i]) begin
            step(vecs[i].live, vecs[i].req, vecs[i].ready);
            check("vec_acc", lv1a_acc, vecs[i].exp_acc);
            check("vec_valid", ev_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check("vec_tag", ev_tag, vecs[i].exp_tag);
            check("vec_occ", occupancy, vecs[i].exp_occ);
            check("vec_cnt", l1a_acc_cnt, vecs[i].exp_cnt);
        end

        // Restart the run so the fill starts from tag 0.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (lv1a_acc) n_acc++;
            if (i == 14) check("fill_full_early", lv2_buffer_full, 0);
            if (i == 15) check("fill_full_at16", lv2_buffer_full, 1);
            if (i >= 16) check("fill_reject_acc", lv1a_acc, 0);
        end
        check("fill_acc_count", n_acc, 16);
        check("fill_occ", occupancy, 16);

        step(1'b1, 1'b0, 1'b1);
        check("drain1_full_drop", lv2_buffer_full, 0);
        check("drain1_occ", occupancy, 15);
        step(1'b1, 1'b1, 1'b0);
        check("refill_acc", lv1a_acc, 1);
        check("refill_full", lv2_buffer_full, 1);
        last_tag = '0;
        for (int i = 0; i < 16; i++) begin
            if (ev_valid) last_tag = ev_tag;
            step(1'b1, 1'b0, 1'b1);
        end
        check("refill_last_tag", last_tag, 16);
        check("drained_occ", occupancy, 0);

        // Push and pop together at occupancy 1.
        step(1'b1, 1'b1, 1'b0);
        check("pp_head0", ev_tag, 17);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b1);
            check("pp_occ", occupancy, 1);
            check("pp_tag", ev_tag, 32'(17 + k));
        end
        step(1'b1, 1'b0, 1'b1);

        // Live off holds contents and ignores requests; the next rise flushes.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("off_acc", lv1a_acc, 0);
            check("off_occ", occupancy, 5);
        end
        step(1'b1, 1'b1, 1'b0);
        check("rise_valid", ev_valid, 0);
        check("rise_cnt", l1a_acc_cnt, 0);
        check("rise_acc", lv1a_acc, 0);
        step(1'b1, 1'b1, 1'b1);
        check("rise_first_tag", ev_tag, 0);
        check("rise_first_cnt", l1a_acc_cnt, 1);

        // Reset mid-burst at occupancy 7.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        check("burst_occ", occupancy, 7);
        lv1a_req = 1'b1;
        async_reset();
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_ignored", lv1a_acc, 0);
        check("post_rst_valid", ev_valid, 0);
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_valid1", ev_valid, 1);
        check("post_rst_tag", ev_tag, 0);

        // Random traffic with alternating drain pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            rdy_pct = ((i / 200) % 2 == 1) ? 20 : 75;
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < rdy_pct));
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_lv2_buf_ctrl
